// File: rtl/cpu_stack_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_stack_commit_pkg
// Description : Shared micro-op, word-type, fault and state encodings for the
//               stage-5 stack commit unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_stack_commit_pkg;

    localparam int WORD_W = 35;

    localparam logic [1:0] UC_NONE    = 2'd0;
    localparam logic [1:0] UC_PUSHALU = 2'd1;
    localparam logic [1:0] UC_PUSHIMM = 2'd2;

    localparam logic [2:0] TYPE_NONE    = 3'd0;
    localparam logic [2:0] TYPE_INTEGER = 3'd1;
    localparam logic [2:0] TYPE_BOOLEAN = 3'd2;
    localparam logic [2:0] TYPE_ADDRESS = 3'd3;

    localparam logic [1:0] ST_FAULT_NONE  = 2'd0;
    localparam logic [1:0] ST_FAULT_UNDER = 2'd1;
    localparam logic [1:0] ST_FAULT_OVER  = 2'd2;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SHADOW = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    // Only the two push encodings push; every other encoding is a no-push.
    function automatic logic is_push(input logic [1:0] uc);
        return (uc == UC_PUSHALU) || (uc == UC_PUSHIMM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_stack_ram.sv
`default_nettype none
// ============================================================================
// Module      : cpu_stack_ram
// Description : Operand-stack storage, one synchronous write port and two
//               combinational read ports; contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_stack_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 35,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule
`default_nettype wire

// File: rtl/cpu_stack_commit.sv
`default_nettype none
// ============================================================================
// Module      : cpu_stack_commit
// Description : Stage-5 commit: pop-then-push on the operand stack, kill
//               redirect with shadow squash, sticky underflow/overflow fault.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_stack_commit
    import cpu_stack_commit_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int SP_W        = 7,
    parameter int KILL_SHADOW = 3
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [1:0]      c__to_push_4a,
    input  logic [10:0]     st__to_pop_4a,
    input  logic [34:0]     st__to_push_4a,
    input  logic            kill_4a,
    input  logic [31:0]     branch_target_4a,
    input  logic [31:0]     pc_4a,
    output logic [34:0]     tos_5a,
    output logic [34:0]     nos_5a,
    output logic [SP_W-1:0] sp_5a,
    output logic            redirect_5a,
    output logic [31:0]     redirect_pc_5a,
    output logic [1:0]      fault_5a,
    output logic [31:0]     fault_pc_5a
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CMP_W = 12;
    localparam int CNT_W = (KILL_SHADOW > 0) ? $clog2(KILL_SHADOW + 1) : 1;
    localparam logic [CMP_W-1:0] DEPTH_X = CMP_W'(DEPTH);

    logic [SP_W-1:0]   sp_q, sp_d;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              redirect_q, redirect_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic [1:0]        fault_q, fault_d;
    logic [31:0]       fault_pc_q, fault_pc_d;

    logic              w_push;
    logic [CMP_W-1:0]  w_pop_ext;
    logic [CMP_W-1:0]  w_sp_ext;
    logic [CMP_W-1:0]  w_new_sp;
    logic              w_run;
    logic              w_under;
    logic              w_over;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [WORD_W-1:0] w_rd_tos;
    logic [WORD_W-1:0] w_rd_nos;

    assign w_push    = is_push(c__to_push_4a);
    assign w_pop_ext = {1'b0, st__to_pop_4a};
    assign w_sp_ext  = {{(CMP_W-SP_W){1'b0}}, sp_q};
    // Wraps when p > sp, but is only consulted once underflow is ruled out.
    assign w_new_sp  = w_sp_ext - w_pop_ext + {{(CMP_W-1){1'b0}}, w_push};
    assign w_run     = (state_q == ST_RUN);
    assign w_under   = w_pop_ext > w_sp_ext;
    assign w_over    = !w_under && (w_new_sp > DEPTH_X);
    // Pop lands first, so the pushed word goes to slot sp - p (mod DEPTH is exact here).
    assign w_waddr   = sp_q[AW-1:0] - st__to_pop_4a[AW-1:0];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sp_q          <= '0;
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            fault_q       <= ST_FAULT_NONE;
            fault_pc_q    <= '0;
        end else begin
            sp_q          <= sp_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (w_under || w_over) begin
                    state_d = ST_FAULT;
                end else if (kill_4a && (KILL_SHADOW > 0)) begin
                    state_d = ST_SHADOW;
                    cnt_d   = CNT_W'(KILL_SHADOW);
                end
            end
            ST_SHADOW: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sp_d          = sp_q;
        w_we          = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        if (w_run) begin
            if (w_under) begin
                fault_d    = ST_FAULT_UNDER;
                fault_pc_d = pc_4a;
            end else if (w_over) begin
                fault_d    = ST_FAULT_OVER;
                fault_pc_d = pc_4a;
            end else begin
                sp_d = w_new_sp[SP_W-1:0];
                w_we = w_push;
                if (kill_4a) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = branch_target_4a;
                end
            end
        end
    end

    cpu_stack_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (st__to_push_4a),
        .raddr_a (sp_q[AW-1:0] - AW'(1)),
        .rdata_a (w_rd_tos),
        .raddr_b (sp_q[AW-1:0] - AW'(2)),
        .rdata_b (w_rd_nos)
    );

    assign tos_5a         = (sp_q == '0) ? '0 : w_rd_tos;
    assign nos_5a         = (sp_q < SP_W'(2)) ? '0 : w_rd_nos;
    assign sp_5a          = sp_q;
    assign redirect_5a    = redirect_q;
    assign redirect_pc_5a = redirect_pc_q;
    assign fault_5a       = fault_q;
    assign fault_pc_5a    = fault_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_stack_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_stack_commit
// Description : Directed and light random stimulus against a reference
//               stack model; expectations queued at drive, checked at output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_stack_commit;
    import cpu_stack_commit_pkg::*;

    localparam int DEPTH       = 64;
    localparam int SP_W        = 7;
    localparam int KILL_SHADOW = 3;
    localparam int MS_RUN      = 0;
    localparam int MS_SHADOW   = 1;
    localparam int MS_FAULT    = 2;

    logic            clk = 1'b0;
    logic            rst_b;
    logic [1:0]      c__to_push_4a;
    logic [10:0]     st__to_pop_4a;
    logic [34:0]     st__to_push_4a;
    logic            kill_4a;
    logic [31:0]     branch_target_4a;
    logic [31:0]     pc_4a;
    logic [34:0]     tos_5a;
    logic [34:0]     nos_5a;
    logic [SP_W-1:0] sp_5a;
    logic            redirect_5a;
    logic [31:0]     redirect_pc_5a;
    logic [1:0]      fault_5a;
    logic [31:0]     fault_pc_5a;

    typedef struct packed {
        logic [SP_W-1:0] sp;
        logic [34:0]     tos;
        logic [34:0]     nos;
        logic            redir;
        logic [31:0]     rpc;
        logic [1:0]      fault;
        logic [31:0]     fpc;
    } exp_t;

    exp_t sb[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [34:0] m_mem [DEPTH];
    int          m_sp;
    int          m_state;
    int          m_cnt;
    logic [31:0] m_rpc;
    logic [1:0]  m_fault;
    logic [31:0] m_fpc;

    cpu_stack_commit #(
        .DEPTH       (DEPTH),
        .SP_W        (SP_W),
        .KILL_SHADOW (KILL_SHADOW)
    ) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .c__to_push_4a    (c__to_push_4a),
        .st__to_pop_4a    (st__to_pop_4a),
        .st__to_push_4a   (st__to_push_4a),
        .kill_4a          (kill_4a),
        .branch_target_4a (branch_target_4a),
        .pc_4a            (pc_4a),
        .tos_5a           (tos_5a),
        .nos_5a           (nos_5a),
        .sp_5a            (sp_5a),
        .redirect_5a      (redirect_5a),
        .redirect_pc_5a   (redirect_pc_5a),
        .fault_5a         (fault_5a),
        .fault_pc_5a      (fault_pc_5a)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_sp    = 0;
        m_state = MS_RUN;
        m_cnt   = 0;
        m_rpc   = '0;
        m_fault = 2'd0;
        m_fpc   = '0;
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases after an edge.
    task automatic do_reset(input string tag);
        rst_b = 1'b0;
        #1;
        check({tag, "_sp"},    35'(sp_5a),          35'd0);
        check({tag, "_tos"},   tos_5a,              35'd0);
        check({tag, "_nos"},   nos_5a,              35'd0);
        check({tag, "_redir"}, 35'(redirect_5a),    35'd0);
        check({tag, "_rpc"},   35'(redirect_pc_5a), 35'd0);
        check({tag, "_fault"}, 35'(fault_5a),       35'd0);
        check({tag, "_fpc"},   35'(fault_pc_5a),    35'd0);
        model_reset();
        sb.delete();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    task automatic step(input logic [1:0] cp, input int pop, input logic [34:0] w,
                        input logic kill, input logic [31:0] tgt, input logic [31:0] pc);
        exp_t e;
        int   nsp;
        int   push;
        logic redir;
        c__to_push_4a    = cp;
        st__to_pop_4a    = 11'(pop);
        st__to_push_4a   = w;
        kill_4a          = kill;
        branch_target_4a = tgt;
        pc_4a            = pc;
        push  = ((cp == 2'd1) || (cp == 2'd2)) ? 1 : 0;
        redir = 1'b0;
        if (m_state == MS_RUN) begin
            nsp = m_sp - pop + push;
            if (pop > m_sp) begin
                m_fault = 2'd1; m_fpc = pc; m_state = MS_FAULT;
            end else if (nsp > DEPTH) begin
                m_fault = 2'd2; m_fpc = pc; m_state = MS_FAULT;
            end else begin
                if (push == 1) m_mem[m_sp - pop] = w;
                m_sp = nsp;
                if (kill) begin
                    redir = 1'b1; m_rpc = tgt; m_state = MS_SHADOW; m_cnt = KILL_SHADOW;
                end
            end
        end else if (m_state == MS_SHADOW) begin
            m_cnt--;
            if (m_cnt == 0) m_state = MS_RUN;
        end
        e.sp    = SP_W'(m_sp);
        e.tos   = (m_sp >= 1) ? m_mem[m_sp - 1] : 35'd0;
        e.nos   = (m_sp >= 2) ? m_mem[m_sp - 2] : 35'd0;
        e.redir = redir;
        e.rpc   = m_rpc;
        e.fault = m_fault;
        e.fpc   = m_fpc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sp",    35'(sp_5a),          35'(e.sp));
        check("tos",   tos_5a,              e.tos);
        check("nos",   nos_5a,              e.nos);
        check("redir", 35'(redirect_5a),    35'(e.redir));
        check("rpc",   35'(redirect_pc_5a), 35'(e.rpc));
        check("fault", 35'(fault_5a),       35'(e.fault));
        check("fpc",   35'(fault_pc_5a),    35'(e.fpc));
    endtask

    function automatic logic [34:0] iw(input int v);
        return {TYPE_INTEGER, 32'(v)};
    endfunction

    initial begin
        rst_b = 1'b0;
        c__to_push_4a = 2'd0; st__to_pop_4a = '0; st__to_push_4a = '0;
        kill_4a = 1'b0; branch_target_4a = '0; pc_4a = '0;
        model_reset();
        @(posedge clk);
        do_reset("reset_init");

        // Single push from reset.
        step(UC_PUSHIMM, 0, 35'h1_0000_002A, 1'b0, 32'h0, 32'h10);
        check("push1_sp",  35'(sp_5a), 35'd1);
        check("push1_tos", tos_5a,     35'h1_0000_002A);
        check("push1_nos", nos_5a,     35'd0);

        // Pop two and push in one cycle.
        do_reset("reset_b");
        for (int i = 1; i <= 3; i++) step(UC_PUSHIMM, 0, iw(i), 1'b0, 32'h0, 32'(4 * i));
        step(UC_PUSHALU, 2, iw(5), 1'b0, 32'h0, 32'h20);
        check("poppush_sp",  35'(sp_5a), 35'd2);
        check("poppush_tos", tos_5a,     {TYPE_INTEGER, 32'h5});
        check("poppush_nos", nos_5a,     {TYPE_INTEGER, 32'h1});
        step(2'd3, 0, iw(99), 1'b0, 32'h0, 32'h24);
        check("nopush_enc_sp", 35'(sp_5a), 35'd2);
        step(2'd0, 0, iw(98), 1'b0, 32'h0, 32'h28);

        // Kill and shadow squash.
        step(UC_NONE, 0, '0, 1'b1, 32'h100, 32'h40);
        check("kill_redir", 35'(redirect_5a),    35'd1);
        check("kill_rpc",   35'(redirect_pc_5a), 35'h100);
        step(UC_PUSHIMM, 0, iw(7), 1'b0, 32'h200, 32'h44);
        step(UC_PUSHIMM, 0, iw(8), 1'b1, 32'h300, 32'h48);
        step(UC_PUSHIMM, 1, iw(9), 1'b0, 32'h0,   32'h4C);
        check("shadow_sp",    35'(sp_5a),       35'd2);
        check("shadow_redir", 35'(redirect_5a), 35'd0);
        step(UC_PUSHIMM, 0, iw(10), 1'b0, 32'h0, 32'h50);
        check("post_shadow_sp",  35'(sp_5a), 35'd3);
        check("post_shadow_tos", tos_5a,     iw(10));

        // Kill then reset in the middle of the shadow.
        step(UC_NONE, 0, '0, 1'b1, 32'h180, 32'h54);
        step(UC_PUSHIMM, 0, iw(11), 1'b0, 32'h0, 32'h58);
        do_reset("reset_shadow");
        step(UC_PUSHIMM, 0, iw(12), 1'b0, 32'h0, 32'h5C);
        check("after_shadow_rst_sp", 35'(sp_5a), 35'd1);

        // Underflow, sticky fault, reset out of fault.
        do_reset("reset_c");
        step(UC_PUSHIMM, 0, iw(1), 1'b0, 32'h0, 32'h84);
        step(UC_NONE, 2, '0, 1'b0, 32'h0, 32'h88);
        check("under_fault", 35'(fault_5a),    35'(ST_FAULT_UNDER));
        check("under_fpc",   35'(fault_pc_5a), 35'h88);
        check("under_sp",    35'(sp_5a),       35'd1);
        step(UC_PUSHIMM, 0, iw(2), 1'b1, 32'h500, 32'h8C);
        step(UC_PUSHALU, 0, iw(3), 1'b0, 32'h0,   32'h90);
        check("fault_hold_sp", 35'(sp_5a), 35'd1);
        do_reset("reset_fault");
        step(UC_PUSHIMM, 0, iw(4), 1'b0, 32'h0, 32'h94);
        check("after_fault_rst_sp", 35'(sp_5a), 35'd1);

        // Overflow from full stack with p = 0.
        do_reset("reset_d");
        for (int i = 0; i < DEPTH; i++) step(UC_PUSHIMM, 0, iw(i), 1'b0, 32'h0, 32'h1000 + 32'(i));
        check("full_sp", 35'(sp_5a), 35'd64);
        step(UC_PUSHIMM, 0, iw(777), 1'b0, 32'h0, 32'h2000);
        check("over_fault", 35'(fault_5a),    35'(ST_FAULT_OVER));
        check("over_fpc",   35'(fault_pc_5a), 35'h2000);
        check("over_sp",    35'(sp_5a),       35'd64);

        // Full stack with p = 1 and push commits.
        do_reset("reset_e");
        for (int i = 0; i < DEPTH; i++) step(UC_PUSHIMM, 0, iw(i), 1'b0, 32'h0, 32'h3000 + 32'(i));
        step(UC_PUSHALU, 1, iw(888), 1'b0, 32'h0, 32'h4000);
        check("full_pp_sp",    35'(sp_5a),    35'd64);
        check("full_pp_fault", 35'(fault_5a), 35'd0);
        check("full_pp_tos",   tos_5a,        iw(888));
        check("full_pp_nos",   nos_5a,        iw(62));

        // Mixed random traffic with legal pop counts.
        do_reset("reset_f");
        for (int i = 0; i < 60; i++) begin
            int pmax;
            pmax = (m_sp < 2) ? m_sp : 2;
            step(2'($urandom_range(0, 3)), int'($urandom_range(0, pmax)),
                 {3'($urandom_range(0, 7)), 32'($urandom)},
                 ($urandom_range(0, 7) == 0), 32'($urandom), 32'h5000 + 32'(4 * i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_stack_commit.md
# cpu_stack_commit

Stage-5 commit unit of the stack-machine pipeline and the consumer of the stage-4 memory outputs. Each cycle it takes the push/pop request, pushed word, kill flag and branch target. It applies pop-then-push to the architectural operand stack and presents top-of-stack/next-on-stack to decode. It issues a one-cycle fetch redirect on kill and squashes the younger instructions already in flight. It detects stack underflow/overflow, latches the faulting PC and halts commit.

## Interface
- DEPTH, 64, operand-stack entries (power of two, ≥ 4)
- SP_W, 7, stack-pointer width; must equal clog2(DEPTH+1)
- KILL_SHADOW, 3, stage-4 inputs discarded after a kill (pipeline stages 1–3)

- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- c__to_push_4a  in  2  push select: UC_PUSHALU, UC_PUSHIMM or no push
- st__to_pop_4a  in  11  pop count, unsigned
- st__to_push_4a  in  35  {type[2:0], value[31:0]} word to push
- kill_4a  in  1  taken branch; this instruction commits, younger ones die
- branch_target_4a  in  32  redirect PC, valid when kill_4a
- pc_4a  in  32  PC of the stage-4 instruction
- tos_5a  out  35  mem[sp-1]; 0 when sp = 0
- nos_5a  out  35  mem[sp-2]; 0 when sp < 2
- sp_5a  out  SP_W  committed stack depth
- redirect_5a  out  1  one-cycle fetch redirect strobe
- redirect_pc_5a  out  32  redirect target
- fault_5a  out  2  0 none, 1 underflow, 2 overflow; sticky
- fault_pc_5a  out  32  PC of the faulting instruction

## Operation
- States: RUN, SHADOW (holds a down-counter of width clog2(KILL_SHADOW+1)), FAULT.
- Push flag: `push = (c__to_push_4a == UC_PUSHALU || c__to_push_4a == UC_PUSHIMM)`. Any other encoding means no push.
- Pop count: p = st__to_pop_4a, zero-extended to 12 bits for comparison.

RUN, on every cycle:
- Underflow: if p > sp, set fault=1, fault_pc=pc_4a, go to FAULT. No stack change and no redirect.
- Overflow: else if sp − p + push > DEPTH, set fault=2, fault_pc=pc_4a, go to FAULT. No stack change and no redirect.
- Commit: otherwise sp ← sp − p + push. If push, write mem[sp−p] ← st__to_push_4a.
- Kill: if kill_4a on a committed instruction, set redirect ← 1, redirect_pc ← branch_target_4a, load the counter with KILL_SHADOW, go to SHADOW. If KILL_SHADOW = 0, stay in RUN.

SHADOW:
- Every stage-4 input is ignored: no push, no pop, no fault, and any kill_4a is ignored.
- The counter decrements each cycle. At 1 → 0 the state returns to RUN, so the next input is evaluated normally.

FAULT:
- All inputs are ignored. It is left only by reset.

Rules that apply in every state:
- redirect_5a is high for exactly one cycle per accepted kill.
- Pop and push in the same cycle: the pop is applied first, and the write lands at the new top. Pop p with push nets sp − p + 1.
- tos_5a and nos_5a are combinational reads of the registered sp and mem, so they reflect all commits up to the last clock edge.

## Timing
- Commit latency is 1 cycle: an input sampled at edge N is visible on sp_5a, tos_5a and nos_5a after edge N.
- redirect_5a and redirect_pc_5a are registered and asserted in the cycle after the kill input.
- Shadow cycles: a kill input at cycle N causes the inputs at N+1 … N+KILL_SHADOW to be discarded. The input at N+KILL_SHADOW+1 is evaluated.
- fault_5a and fault_pc_5a are registered and valid the cycle after the faulting input. They hold until reset.

Reset values:
- sp=0, state=RUN, counter=0, redirect_5a=0, redirect_pc_5a=0, fault_5a=0, fault_pc_5a=0. Therefore tos_5a=0 and nos_5a=0.
- Memory contents are not reset.

Reset mid-operation:
- Asserting rst_b during SHADOW or FAULT returns to RUN immediately.
- The first input sampled after deassertion is evaluated.

Boundaries:
- sp = DEPTH with push and p = 0 → overflow.
- sp = DEPTH with push and p = 1 → commits; sp stays DEPTH.
- p = 0 with no push → no change; this is legal.

## Structure
- opcode.vh, shared, holds:
  - UC_PUSHALU and UC_PUSHIMM
  - TYPE_*
  - new constants: ST_FAULT_NONE, ST_FAULT_UNDER, ST_FAULT_OVER, and the 2-bit state encodings
- cpu_stack_ram is one sub-module:
  - DEPTH × 35 flop array with 1 synchronous write port and 2 combinational read ports
  - not reset
- cpu_stack_commit holds the sp/state/counter control and the output registers.

## Test plan
- Push: from reset, one input with UC_PUSHIMM and push word 35'h1_0000_002A → next cycle sp_5a=1, tos_5a=35'h1_0000_002A, nos_5a=0.
- Pop and push: push 1, 2, 3 (sp=3), then pop 2 with UC_PUSHALU word {TYPE_INTEGER, 32'h5} → sp=2, tos_5a={TYPE_INTEGER,5}, nos_5a=word 1.
- Kill and shadow: kill_4a with target 32'h100 at pc 32'h40 → redirect_5a high 1 cycle with redirect_pc_5a=32'h100. The next 3 inputs, each a push with one carrying kill_4a, leave sp unchanged with no redirect. The 4th push commits.
- Underflow: sp=1, pop 2 at pc 32'h88 → fault_5a=1, fault_pc_5a=32'h88, sp stays 1. Later pushes are ignored.
- Overflow: fill to sp=64, then push with p=0 → fault_5a=2. Repeat from a full stack with p=1 and push → commits, sp=64, no fault.
- Reset: assert rst_b mid-SHADOW and mid-FAULT → all outputs return to their reset values. The first push after release commits with sp=1.
